// File: rtl/div.sv
// Sequential restoring divider, MIPS DIV semantics: quotient to low, remainder to high.
// Define DIV_UNSIGNED_EN to add the is_unsigned port (DIVU semantics).
module div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivCtrl,
`ifdef DIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] high,
   output logic [WIDTH-1:0] low,
   output logic             div_end,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic             bz_q, bz_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] low_q, low_d;
   logic             end_q, end_d;
   logic             zero_q, zero_d;

   logic             uns;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   shl;
   logic [WIDTH+1:0] trial;

`ifdef DIV_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign mag_a = (!uns && a[WIDTH-1]) ? -a : a;
   assign mag_b = (!uns && b[WIDTH-1]) ? -b : b;

   // rem < divisor, so the shifted partial remainder always fits WIDTH+1 bits
   assign shl   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign trial = {1'b0, shl} - {2'b00, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      bz_d    = bz_q;
      high_d  = high_q;
      low_d   = low_q;
      end_d   = end_q;
      zero_d  = zero_q;
      if (DivCtrl) begin
         sgnq_d  = !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
         sgnr_d  = !uns && a[WIDTH-1];
         rem_d   = '0;
         quo_d   = mag_a;
         dvs_d   = mag_b;
         cnt_d   = CW'(WIDTH - 1);
         end_d   = 1'b0;
         zero_d  = 1'b0;
         bz_d    = (b == '0);
         state_d = (b == '0) ? FIX : RUN;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               rem_d = trial[WIDTH+1] ? shl : trial[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
               end_d   = 1'b1;
               state_d = DONE;
               if (bz_q) begin
                  zero_d = 1'b1;
               end else begin
                  low_d  = sgnq_q ? -quo_q : quo_q;
                  high_d = sgnr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         bz_q    <= 1'b0;
         high_q  <= '0;
         low_q   <= '0;
         end_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
         bz_q    <= bz_d;
         high_q  <= high_d;
         low_q   <= low_d;
         end_q   <= end_d;
         zero_q  <= zero_d;
      end
   end

   assign high     = high_q;
   assign low      = low_q;
   assign div_end  = end_q;
   assign div_zero = zero_q;

endmodule
